// File: rtl/press_generator.sv
// Key-press transmitter: turns a one-cycle request into an active-low press/release waveform.
// Optional LFSR-driven cyber player is compiled in when PRESS_GEN_AUTO_EN is defined.
module press_generator #(
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic [HOLD_W-1:0] gap_len,
  input  logic [8:0]        auto_threshold,
  output logic              key_n,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  press_count
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t            r_state;
  logic [HOLD_W-1:0] r_cnt;
  logic [HOLD_W-1:0] r_gap;
  logic              r_pending;
  logic              r_key_n;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_press_count;

  logic [HOLD_W-1:0] w_hold;
  logic [HOLD_W-1:0] w_gap;
  logic              w_trig;
  logic              w_start;

  assign w_hold = (hold_len == '0) ? HOLD_W'(1) : hold_len;
  assign w_gap  = (gap_len  == '0) ? HOLD_W'(1) : gap_len;

`ifdef PRESS_GEN_AUTO_EN
  logic [9:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= '0;
    else       r_lfsr <= {r_lfsr[8:0], ~(r_lfsr[9] ^ r_lfsr[6])};
  end

  assign w_trig = req | ({1'b0, auto_threshold} > r_lfsr);
`else
  logic w_unused_thr;
  assign w_unused_thr = ^auto_threshold;
  assign w_trig       = req;
`endif

  // A request arriving on the final gap edge chains straight into the next press.
  assign w_start = ((r_state == IDLE) && w_trig) ||
                   ((r_state == GAP) && (r_cnt == '0) && (r_pending || req));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_gap         <= HOLD_W'(1);
      r_pending     <= 1'b0;
      r_key_n       <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != IDLE) && req) r_pending <= 1'b1;

      case (r_state)
        PRESS: begin
          if (r_cnt == '0) begin
            r_state <= GAP;
            r_key_n <= 1'b1;
            r_cnt   <= r_gap - 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase

      // Press entry overrides the per-state updates above.
      if (w_start) begin
        r_state   <= PRESS;
        r_key_n   <= 1'b0;
        r_busy    <= 1'b1;
        r_cnt     <= w_hold - 1'b1;
        r_gap     <= w_gap;
        r_pending <= 1'b0;
        if (r_press_count != '1) r_press_count <= r_press_count + 1'b1;
      end
    end
  end

  assign key_n       = r_key_n;
  assign busy        = r_busy;
  assign done        = r_done;
  assign press_count = r_press_count;

endmodule
